// File: rtl/spi_seq_pkg.sv
// Shared types and byte-composition helpers for the SPI register-access sequencer.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SEND_ADDR,
        ST_WAIT_ADDR,
        ST_SEND_DATA,
        ST_WAIT_DATA,
        ST_HOLD,
        ST_GAP
    } seq_state_e;

    localparam logic [7:0] DUMMY_BYTE = 8'h00;
    localparam logic       RW_READ    = 1'b1;

    function automatic logic [7:0] addr_byte(input logic rw, input logic [6:0] addr);
        return {rw, addr};
    endfunction

endpackage

// File: rtl/spi_reg_sequencer_if.sv
// Command / write-data / read-data handshake bundle between the sensor drivers and the sequencer.
interface spi_reg_sequencer_if #(
    parameter int MAX_LEN = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_rw;
    logic [6:0]       cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             wr_valid;
    logic             wr_ready;
    logic [7:0]       wr_data;
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic             done;

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_valid, wr_data,
        output cmd_ready, wr_ready, rd_valid, rd_data, done
    );

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_valid, wr_data,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done
    );

endinterface

// File: rtl/spi_cs_timer.sv
// Loadable down-counter with terminal-count flag; saturates at zero instead of wrapping.
module spi_cs_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/spi_reg_sequencer.sv
// Turns one register-access command into a chip-selected burst of SPI bytes with
// programmable CS setup, hold and idle spacing around the byte-level SPI master.
module spi_reg_sequencer
    import spi_seq_pkg::*;
#(
    parameter int MAX_LEN  = 8,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 4
) (
    input  logic                clk,
    input  logic                rst,
    spi_reg_sequencer_if.slave  bus,
    output logic                cs_n,
    output logic                spi_start,
    output logic [7:0]          spi_tx,
    input  logic [7:0]          spi_rx,
    input  logic                spi_busy,
    input  logic                spi_new_data
);

    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int MAX_DLY = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                                                  : ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
    localparam int DLY_W   = $clog2(MAX_DLY + 1);

    seq_state_e       state_q, state_d;
    logic             rw_q, rw_d;
    logic [6:0]       addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             cs_n_q, cs_n_d;
    logic             start_q, start_d;
    logic [7:0]       tx_q, tx_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             done_q, done_d;

    logic             tmr_load;
    logic [DLY_W-1:0] tmr_val;
    logic             tmr_tc;
    logic             accept;
    logic [LEN_W-1:0] len_eff;

    spi_cs_timer #(.W(DLY_W)) u_cs_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        if (bus.cmd_len == '0)
            len_eff = LEN_W'(1);
        else if (bus.cmd_len > LEN_W'(MAX_LEN))
            len_eff = LEN_W'(MAX_LEN);
        else
            len_eff = bus.cmd_len;
    end

    // Accepting in the last GAP cycle keeps cs_n high for exactly CS_IDLE cycles.
    assign bus.cmd_ready = ~rst & ~spi_busy &
                           ((state_q == ST_IDLE) | ((state_q == ST_GAP) & tmr_tc));
    assign bus.wr_ready  = ~rst & (state_q == ST_SEND_DATA) & (rw_q != RW_READ) & ~start_q;
    assign accept        = bus.cmd_valid & bus.cmd_ready;

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        cs_n_d     = cs_n_q;
        start_d    = 1'b0;
        tx_d       = tx_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        case (state_q)
            ST_IDLE: ;
            ST_SETUP: begin
                if (tmr_tc) begin
                    state_d = ST_SEND_ADDR;
                    start_d = 1'b1;
                    tx_d    = addr_byte(rw_q, addr_q);
                end
            end
            ST_SEND_ADDR: state_d = ST_WAIT_ADDR;
            ST_WAIT_ADDR: begin
                if (spi_new_data) begin
                    state_d = ST_SEND_DATA;
                    if (rw_q == RW_READ) begin
                        start_d = 1'b1;
                        tx_d    = DUMMY_BYTE;
                    end
                end
            end
            // Reads enter with start already raised; writes wait here for a data byte.
            ST_SEND_DATA: begin
                if (start_q) begin
                    state_d = ST_WAIT_DATA;
                end else if (bus.wr_valid && bus.wr_ready) begin
                    start_d = 1'b1;
                    tx_d    = bus.wr_data;
                end
            end
            ST_WAIT_DATA: begin
                if (spi_new_data) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rw_q == RW_READ) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = spi_rx;
                    end
                    if (rem_q > LEN_W'(1)) begin
                        state_d = ST_SEND_DATA;
                        if (rw_q == RW_READ) begin
                            start_d = 1'b1;
                            tx_d    = DUMMY_BYTE;
                        end
                    end else begin
                        state_d  = ST_HOLD;
                        tmr_load = 1'b1;
                        tmr_val  = DLY_W'(CS_HOLD - 1);
                    end
                end
            end
            ST_HOLD: begin
                if (tmr_tc) begin
                    state_d  = ST_GAP;
                    cs_n_d   = 1'b1;
                    done_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = DLY_W'(CS_IDLE - 1);
                end
            end
            ST_GAP: begin
                if (tmr_tc)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d  = ST_SETUP;
            rw_d     = bus.cmd_rw;
            addr_d   = bus.cmd_addr;
            rem_d    = len_eff;
            cs_n_d   = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = DLY_W'(CS_SETUP - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            rem_q      <= '0;
            cs_n_q     <= 1'b1;
            start_q    <= 1'b0;
            tx_q       <= DUMMY_BYTE;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            cs_n_q     <= cs_n_d;
            start_q    <= start_d;
            tx_q       <= tx_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
        end
    end

    assign cs_n         = cs_n_q;
    assign spi_start    = start_q;
    assign spi_tx       = tx_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed bench for spi_reg_sequencer with a small SPI-master responder model.
module tb_spi_reg_sequencer;

    localparam int MAX_LEN  = 8;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int CS_IDLE  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n, spi_start;
    logic [7:0] spi_tx;
    logic [7:0] spi_rx = 8'h00;
    logic       spi_busy;
    logic       spi_new_data = 1'b0;
    logic       m_busy = 1'b0;
    logic       busy_force = 1'b0;
    int         m_cnt = 0;

    assign spi_busy = m_busy | busy_force;

    spi_reg_sequencer_if #(.MAX_LEN(MAX_LEN)) bus();

    spi_reg_sequencer #(
        .MAX_LEN(MAX_LEN), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .cs_n         (cs_n),
        .spi_start    (spi_start),
        .spi_tx       (spi_tx),
        .spi_rx       (spi_rx),
        .spi_busy     (spi_busy),
        .spi_new_data (spi_new_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // responder / monitor state
    logic [7:0] rx_tab [128];
    logic [7:0] tx_log [128];
    logic [7:0] rd_log [128];
    int start_cyc [128];
    int nd_cyc    [128];
    int fall_log  [128];
    int rise_log  [128];
    int tx_n = 0, rd_n = 0, m_pn = 0, done_n = 0, wr_n = 0, fall_n = 0, rise_n = 0;
    int acc_cyc = 0, done_cyc = 0, spur_req = 0, spur_done = 0;
    logic cs_prev = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    always @(negedge clk) begin
        spi_new_data = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_cnt  = 0;
        end else begin
            if (m_busy) begin
                if (m_cnt == 0) begin
                    spi_new_data = 1'b1;
                    spi_rx = rx_tab[m_pn & 127];
                    nd_cyc[m_pn & 127] = cyc;
                    m_pn++;
                    m_busy = 1'b0;
                end else begin
                    m_cnt--;
                end
            end else if (spur_req != spur_done) begin
                spi_new_data = 1'b1;
                spi_rx = 8'hEE;
                spur_done++;
            end
            if (spi_start) begin
                tx_log[tx_n & 127] = spi_tx;
                start_cyc[tx_n & 127] = cyc;
                tx_n++;
                m_busy = 1'b1;
                m_cnt  = 2;
            end
        end
        if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
        if (cs_prev && !cs_n) begin fall_log[fall_n & 127] = cyc; fall_n++; end
        if (!cs_prev && cs_n) begin rise_log[rise_n & 127] = cyc; rise_n++; end
        if (cs_n === 1'b0 || cs_n === 1'b1) cs_prev = cs_n;
        if (bus.rd_valid) begin rd_log[rd_n & 127] = bus.rd_data; rd_n++; end
        if (bus.done) begin done_n++; done_cyc = cyc; end
        if (bus.wr_valid && bus.wr_ready) wr_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cmd_hs(input string tag);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.cmd_valid && bus.cmd_ready) break;
        end
        if (k == 300) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic issue_cmd(input logic rw, input logic [6:0] addr, input logic [3:0] len);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = rw;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        wait_cmd_hs("cmd");
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k;
        for (k = 0; k < 500; k++) begin
            if (done_n >= target) break;
            @(negedge clk);
        end
        if (k == 500) check("done_timeout", 32'(done_n), 32'(target));
    endtask

    task automatic wait_count(input string tag, input int which, input int target);
        int k;
        for (k = 0; k < 500; k++) begin
            if (((which == 0) ? tx_n : rd_n) >= target) break;
            @(negedge clk);
        end
        if (k == 500) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic put_wr(input logic [7:0] d);
        int k;
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.wr_ready) break;
        end
        if (k == 300) check("wr_hs_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pb, tb, rb, db, fb, rsb, wb, sb;
        for (int i = 0; i < 128; i++) rx_tab[i] = 8'h40 + 8'(i);
        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = 1'b0;
        bus.cmd_addr  = 7'h00;
        bus.cmd_len   = 4'd0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = 8'h00;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n",      32'(cs_n), 32'd1);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_wr_ready",  32'(bus.wr_ready), 32'd0);
        check("rst_start",     32'(spi_start), 32'd0);
        check("rst_tx",        32'(spi_tx), 32'h00);
        check("rst_rd_valid",  32'(bus.rd_valid), 32'd0);
        check("rst_rd_data",   32'(bus.rd_data), 32'h00);
        check("rst_done",      32'(bus.done), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        // single-byte read of 0x0F returning 0xA5
        pb = m_pn; tb = tx_n; rb = rd_n; db = done_n; fb = fall_n; rsb = rise_n;
        rx_tab[(pb + 1) & 127] = 8'hA5;
        issue_cmd(1'b1, 7'h0F, 4'd1);
        wait_done(db + 1);
        repeat (2) @(negedge clk);
        check("rd1_tx_cnt",    32'(tx_n - tb), 32'd2);
        check("rd1_addr_byte", 32'(tx_log[tb & 127]), 32'h8F);
        check("rd1_dummy",     32'(tx_log[(tb + 1) & 127]), 32'h00);
        check("rd1_rd_cnt",    32'(rd_n - rb), 32'd1);
        check("rd1_rd_data",   32'(rd_log[rb & 127]), 32'hA5);
        check("rd1_done_cnt",  32'(done_n - db), 32'd1);
        check("rd1_cs_fall",   32'(fall_log[fb & 127]), 32'(acc_cyc + 1));
        check("rd1_first_start", 32'(start_cyc[tb & 127]), 32'(acc_cyc + 1 + CS_SETUP));
        check("rd1_next_start",  32'(start_cyc[(tb + 1) & 127]), 32'(nd_cyc[pb & 127] + 1));
        check("rd1_cs_rise",   32'(rise_log[rsb & 127]), 32'(nd_cyc[(pb + 1) & 127] + CS_HOLD + 1));
        check("rd1_done_with_rise", 32'(done_cyc), 32'(rise_log[rsb & 127]));

        // 3-byte write with a 10-cycle stall before the second byte
        tb = tx_n; rb = rd_n; db = done_n; fb = fall_n; wb = wr_n;
        issue_cmd(1'b0, 7'h20, 4'd3);
        put_wr(8'h11);
        bus.wr_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("wr_gap_cs_low",  32'(cs_n), 32'd0);
        check("wr_gap_tx_cnt",  32'(tx_n - tb), 32'd2);
        put_wr(8'h22);
        put_wr(8'h33);
        bus.wr_valid = 1'b0;
        wait_done(db + 1);
        check("wr_tx_cnt", 32'(tx_n - tb), 32'd4);
        check("wr_tx0",    32'(tx_log[tb & 127]), 32'h20);
        check("wr_tx1",    32'(tx_log[(tb + 1) & 127]), 32'h11);
        check("wr_tx2",    32'(tx_log[(tb + 2) & 127]), 32'h22);
        check("wr_tx3",    32'(tx_log[(tb + 3) & 127]), 32'h33);
        check("wr_hs_cnt", 32'(wr_n - wb), 32'd3);
        check("wr_no_rd",  32'(rd_n - rb), 32'd0);
        check("wr_one_cs", 32'(fall_n - fb), 32'd1);

        // length 0 -> one byte
        tb = tx_n; rb = rd_n; db = done_n;
        issue_cmd(1'b1, 7'h01, 4'd0);
        wait_done(db + 1);
        check("len0_tx_cnt", 32'(tx_n - tb), 32'd2);
        check("len0_rd_cnt", 32'(rd_n - rb), 32'd1);

        // length 15 -> clamped to MAX_LEN
        pb = m_pn; tb = tx_n; rb = rd_n; db = done_n;
        issue_cmd(1'b1, 7'h02, 4'd15);
        wait_done(db + 1);
        check("len15_tx_cnt", 32'(tx_n - tb), 32'd9);
        check("len15_addr",   32'(tx_log[tb & 127]), 32'h82);
        check("len15_rd_cnt", 32'(rd_n - rb), 32'd8);
        check("len15_rd_last", 32'(rd_log[(rb + 7) & 127]), 32'(rx_tab[(pb + 8) & 127]));

        // two back-to-back commands held on cmd_valid
        tb = tx_n; db = done_n; fb = fall_n; rsb = rise_n;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b1; bus.cmd_addr = 7'h10; bus.cmd_len = 4'd1;
        wait_cmd_hs("b2b_a");
        @(posedge clk); #1;
        bus.cmd_addr = 7'h11;
        wait_cmd_hs("b2b_b");
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        wait_done(db + 2);
        check("b2b_done_cnt", 32'(done_n - db), 32'd2);
        check("b2b_cs_gap",   32'(fall_log[(fb + 1) & 127] - rise_log[rsb & 127]), 32'(CS_IDLE));
        check("b2b_addr2",    32'(tx_log[(tb + 2) & 127]), 32'h91);

        // reset during the second data byte of a 4-byte read
        pb = m_pn; tb = tx_n; rb = rd_n; db = done_n;
        issue_cmd(1'b1, 7'h05, 4'd4);
        wait_count("rst_mid", 0, tb + 3);
        @(posedge clk); #1;
        rst = 1'b1;
        busy_force = 1'b1;
        @(negedge clk);
        check("rst_mid_ready_in_rst", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_cs_n", 32'(cs_n), 32'd1);
        fb = fall_n;
        repeat (20) @(negedge clk);
        check("rst_mid_rd_cnt",    32'(rd_n - rb), 32'd1);
        check("rst_mid_rd_data",   32'(rd_log[rb & 127]), 32'(rx_tab[(pb + 1) & 127]));
        check("rst_mid_no_done",   32'(done_n - db), 32'd0);
        check("rst_mid_cs_stays",  32'(fall_n - fb), 32'd0);
        check("rst_mid_ready_busy", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk); #1 busy_force = 1'b0;
        @(negedge clk);
        check("rst_mid_ready_free", 32'(bus.cmd_ready), 32'd1);

        // spurious new_data in SETUP and HOLD
        pb = m_pn; tb = tx_n; rb = rd_n; db = done_n; rsb = rise_n; sb = spur_done;
        issue_cmd(1'b1, 7'h33, 4'd1);
        spur_req++;
        wait_count("spur_rd", 1, rb + 1);
        @(posedge clk); #1 spur_req++;
        wait_done(db + 1);
        repeat (2) @(negedge clk);
        check("spur_pulses",  32'(spur_done - sb), 32'd2);
        check("spur_rd_cnt",  32'(rd_n - rb), 32'd1);
        check("spur_tx_cnt",  32'(tx_n - tb), 32'd2);
        check("spur_start",   32'(start_cyc[tb & 127]), 32'(acc_cyc + 1 + CS_SETUP));
        check("spur_cs_rise", 32'(rise_log[rsb & 127]), 32'(nd_cyc[(pb + 1) & 127] + CS_HOLD + 1));
        check("spur_done_cnt", 32'(done_n - db), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
